// File: rtl/draw_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : draw_sequencer
// Description : Runs fillscreen then the circle engine on one start request,
//               and merges their plot streams into one clipped pixel stream.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sequencer #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    input  logic [2:0]  bg_colour,
    input  logic [2:0]  fg_colour,
    input  logic [7:0]  centre_x,
    input  logic [6:0]  centre_y,
    input  logic [7:0]  radius,
    output logic        fs_start,
    output logic [2:0]  fs_colour,
    input  logic        fs_done,
    input  logic [7:0]  fs_x,
    input  logic [6:0]  fs_y,
    input  logic [2:0]  fs_pcolour,
    input  logic        fs_plot,
    output logic        cir_start,
    output logic [2:0]  cir_colour,
    output logic [7:0]  cir_centre_x,
    output logic [6:0]  cir_centre_y,
    output logic [7:0]  cir_radius,
    input  logic        cir_done,
    input  logic [7:0]  cir_x,
    input  logic [6:0]  cir_y,
    input  logic [2:0]  cir_pcolour,
    input  logic        cir_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] plot_count
);

    localparam logic [8:0]  c_SCREEN_W  = 9'(SCREEN_W);
    localparam logic [7:0]  c_SCREEN_H  = 8'(SCREEN_H);
    localparam logic [14:0] c_COUNT_MAX = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_fs_start;
    logic        r_cir_start;
    logic        r_done;
    logic [2:0]  r_bg;
    logic [2:0]  r_fg;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [7:0]  r_rad;
    logic [7:0]  r_vga_x;
    logic [6:0]  r_vga_y;
    logic [2:0]  r_vga_colour;
    logic        r_vga_plot;
    logic [14:0] r_count;

    logic        w_in_draw;
    logic        w_strobe;
    logic [7:0]  w_src_x;
    logic [6:0]  w_src_y;
    logic [2:0]  w_src_c;
    logic        w_forward;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fs_start  <= 1'b0;
            r_cir_start <= 1'b0;
            r_done      <= 1'b0;
            r_bg        <= 3'd0;
            r_fg        <= 3'd0;
            r_cx        <= 8'd0;
            r_cy        <= 7'd0;
            r_rad       <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bg       <= bg_colour;
                        r_fg       <= fg_colour;
                        r_cx       <= centre_x;
                        r_cy       <= centre_y;
                        r_rad      <= radius;
                        r_fs_start <= 1'b1;
                        r_state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (fs_done) begin
                        r_fs_start  <= 1'b0;
                        r_cir_start <= 1'b1;
                        r_state     <= DRAW;
                    end
                end
                DRAW: begin
                    if (cir_done) begin
                        r_cir_start <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Only the engine owning the current phase may plot; the other stream is ignored.
    assign w_in_draw = (r_state == DRAW);
    assign w_strobe  = ((r_state == CLEAR) && fs_plot) || (w_in_draw && cir_plot);
    assign w_src_x   = w_in_draw ? cir_x       : fs_x;
    assign w_src_y   = w_in_draw ? cir_y       : fs_y;
    assign w_src_c   = w_in_draw ? cir_pcolour : fs_pcolour;
    assign w_forward = w_strobe && ({1'b0, w_src_x} < c_SCREEN_W)
                                && ({1'b0, w_src_y} < c_SCREEN_H);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
            r_count      <= 15'd0;
        end else begin
            r_vga_plot <= w_forward;
            if (w_forward) begin
                r_vga_x      <= w_src_x;
                r_vga_y      <= w_src_y;
                r_vga_colour <= w_src_c;
            end
            if ((r_state == IDLE) && start) begin
                r_count <= 15'd0;
            end else if (w_forward && (r_count != c_COUNT_MAX)) begin
                r_count <= r_count + 15'd1;
            end
        end
    end

    assign done         = r_done;
    assign fs_start     = r_fs_start;
    assign fs_colour    = r_bg;
    assign cir_start    = r_cir_start;
    assign cir_colour   = r_fg;
    assign cir_centre_x = r_cx;
    assign cir_centre_y = r_cy;
    assign cir_radius   = r_rad;
    assign vga_x        = r_vga_x;
    assign vga_y        = r_vga_y;
    assign vga_colour   = r_vga_colour;
    assign vga_plot     = r_vga_plot;
    assign plot_count   = r_count;

endmodule
`default_nettype wire
